reg_ram_arbiter: RTL and testbench

//  Shares the single port of the 8-byte register RAM (reg_ram_8B) between two requesters.

---
 rtl/reg_ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_reg_ram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ram_arbiter.sv
// reg_ram_arbiter: two-port arbiter in front of the single-port 8-byte register RAM.
// Port A is the CPU core and port B is the debug/scan port. Each access runs
// IDLE -> ACCESS -> ACK, one cycle per state. All outputs come straight from flops.
module reg_ram_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,  // 0: round-robin on a tie, 1: A always wins a tie
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              a_req_in,
  input  logic              a_we_in,
  input  logic [ADDR_W-1:0] a_addr_in,
  input  logic [DATA_W-1:0] a_data_in,
  output logic              a_ack_out,
  output logic [DATA_W-1:0] a_data_out,
  input  logic              b_req_in,
  input  logic              b_we_in,
  input  logic [ADDR_W-1:0] b_addr_in,
  input  logic [DATA_W-1:0] b_data_in,
  output logic              b_ack_out,
  output logic [DATA_W-1:0] b_data_out,
  output logic              ram_en_out,
  output logic              ram_we_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_wdata_out,
  input  logic [DATA_W-1:0] ram_rdata_in,
  output logic              busy_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  // sel / last_grant encoding: 0 = port A, 1 = port B
  logic                sel_q, sel_d;
  logic                last_grant_q, last_grant_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [DATA_W-1:0]   a_data_q, a_data_d;
  logic [DATA_W-1:0]   b_data_q, b_data_d;
  // The ram_* flops double as the latched command: they are loaded on grant
  // and drive the RAM directly during ACCESS.
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                busy_q, busy_d;
  logic                grant_b;

  // Next-state logic: arbitration in IDLE, read capture and ack in ACCESS.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_data_d     = a_data_q;
    b_data_d     = b_data_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    grant_b      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (a_req_in && b_req_in) begin
          grant_b = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
          grant_b = b_req_in;
        end
        if (a_req_in || b_req_in) begin
          state_d      = ST_ACCESS;
          sel_d        = grant_b;
          last_grant_d = grant_b;
          ram_en_d     = 1'b1;
          ram_we_d     = grant_b ? b_we_in   : a_we_in;
          ram_addr_d   = grant_b ? b_addr_in : a_addr_in;
          ram_wdata_d  = grant_b ? b_data_in : a_data_in;
        end
      end
      ST_ACCESS: begin
        state_d = ST_ACK;
        // ram_we_q still holds the latched command direction here
        if (!ram_we_q) begin
          if (sel_q) b_data_d = ram_rdata_in;
          else       a_data_d = ram_rdata_in;
        end
        if (sel_q) b_ack_d = 1'b1;
        else       a_ack_d = 1'b1;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset; B is last_grant so A wins the first tie.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_data_q     <= '0;
      b_data_q     <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign a_ack_out     = a_ack_q;
  assign b_ack_out     = b_ack_q;
  assign a_data_out    = a_data_q;
  assign b_data_out    = b_data_q;
  assign ram_en_out    = ram_en_q;
  assign ram_we_out    = ram_we_q;
  assign ram_addr_out  = ram_addr_q;
  assign ram_wdata_out = ram_wdata_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_reg_ram_arbiter.sv
// tb_reg_ram_arbiter: drives the arbiter (round-robin and fixed-priority builds) and
// compares every cycle against a transaction-level model of grants, RAM contents and read data.
module tb_reg_ram_arbiter;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       rst_in;
  logic       init_mem;

  // round-robin instance signals
  logic       a_req_in, a_we_in, b_req_in, b_we_in;
  logic [2:0] a_addr_in, b_addr_in;
  logic [7:0] a_data_in, b_data_in;
  logic       a_ack_out, b_ack_out;
  logic [7:0] a_data_out, b_data_out;
  logic       ram_en_out, ram_we_out, busy_out;
  logic [2:0] ram_addr_out;
  logic [7:0] ram_wdata_out, ram_rdata_in;

  // fixed-priority instance signals
  logic       f_a_req_in, f_a_we_in, f_b_req_in, f_b_we_in;
  logic [2:0] f_a_addr_in, f_b_addr_in;
  logic [7:0] f_a_data_in, f_b_data_in;
  logic       f_a_ack_out, f_b_ack_out;
  logic [7:0] f_a_data_out, f_b_data_out;
  logic       f_ram_en_out, f_ram_we_out, f_busy_out;
  logic [2:0] f_ram_addr_out;
  logic [7:0] f_ram_wdata_out, f_ram_rdata_in;

  reg_ram_arbiter #(.FIXED_PRIO(1'b0), .ADDR_W(3), .DATA_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .a_req_in(a_req_in), .a_we_in(a_we_in), .a_addr_in(a_addr_in), .a_data_in(a_data_in),
    .a_ack_out(a_ack_out), .a_data_out(a_data_out),
    .b_req_in(b_req_in), .b_we_in(b_we_in), .b_addr_in(b_addr_in), .b_data_in(b_data_in),
    .b_ack_out(b_ack_out), .b_data_out(b_data_out),
    .ram_en_out(ram_en_out), .ram_we_out(ram_we_out), .ram_addr_out(ram_addr_out),
    .ram_wdata_out(ram_wdata_out), .ram_rdata_in(ram_rdata_in), .busy_out(busy_out)
  );

  reg_ram_arbiter #(.FIXED_PRIO(1'b1), .ADDR_W(3), .DATA_W(8)) dut_fp (
    .clk_in(clk_in), .rst_in(rst_in),
    .a_req_in(f_a_req_in), .a_we_in(f_a_we_in), .a_addr_in(f_a_addr_in), .a_data_in(f_a_data_in),
    .a_ack_out(f_a_ack_out), .a_data_out(f_a_data_out),
    .b_req_in(f_b_req_in), .b_we_in(f_b_we_in), .b_addr_in(f_b_addr_in), .b_data_in(f_b_data_in),
    .b_ack_out(f_b_ack_out), .b_data_out(f_b_data_out),
    .ram_en_out(f_ram_en_out), .ram_we_out(f_ram_we_out), .ram_addr_out(f_ram_addr_out),
    .ram_wdata_out(f_ram_wdata_out), .ram_rdata_in(f_ram_rdata_in), .busy_out(f_busy_out)
  );

  // 8-byte register RAM: combinational read, write on the rising edge; never reset by rst_in
  logic [7:0] ram_mem [8];
  always @(posedge clk_in) begin
    if (init_mem) begin
      for (int i = 0; i < 8; i++) ram_mem[i] <= 8'h00;
    end else if (ram_en_out && ram_we_out) begin
      ram_mem[ram_addr_out] <= ram_wdata_out;
    end
  end
  assign ram_rdata_in = ram_mem[ram_addr_out];

  // fixed-priority instance only reads; its RAM returns a pattern derived from the address
  assign f_ram_rdata_in = {5'b10100, f_ram_addr_out};

  // reference model state (port index 0 = A, 1 = B)
  logic [7:0] mdl_mem [8];
  bit         last_g;
  logic [7:0] exp_dout [2];

  int n_cmp = 0;
  int n_bad = 0;
  int n_round = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One transaction round starting in IDLE: each enabled port requests once and holds until ack.
  task automatic do_round(input bit a_on, input bit a_we, input logic [2:0] a_ad, input logic [7:0] a_wd,
                          input bit b_on, input bit b_we, input logic [2:0] b_ad, input logic [7:0] b_wd,
                          input bit perturb);
    bit         on [2];
    bit         we [2];
    logic [2:0] ad [2];
    logic [7:0] wd [2];
    logic [7:0] rd_val [2];
    int         ack_cyc [2];
    bit         two, any, first, p, exp_en, exp_busy;

    on[0] = a_on; we[0] = a_we; ad[0] = a_ad; wd[0] = a_wd;
    on[1] = b_on; we[1] = b_we; ad[1] = b_ad; wd[1] = b_wd;
    rd_val[0] = 8'h00; rd_val[1] = 8'h00;
    ack_cyc[0] = 0; ack_cyc[1] = 0;
    two   = a_on && b_on;
    any   = a_on || b_on;
    first = two ? ~last_g : b_on;

    if (any) begin
      ack_cyc[first] = 2;
      if (two) ack_cyc[~first] = 5;
      for (int k = 0; k < 2; k++) begin
        p = (k == 0) ? first : ~first;
        if (on[p]) begin
          if (we[p]) mdl_mem[ad[p]] = wd[p];
          else       rd_val[p] = mdl_mem[ad[p]];
        end
      end
      last_g = two ? ~first : first;
    end

    n_round++;
    $display("round %0d: A(req=%0d we=%0d r%0d d=%02h) B(req=%0d we=%0d r%0d d=%02h) first=%s",
             n_round, a_on, a_we, a_ad, a_wd, b_on, b_we, b_ad, b_wd,
             !any ? "-" : (first ? "B" : "A"));

    a_req_in = a_on; a_we_in = a_we; a_addr_in = a_ad; a_data_in = a_wd;
    b_req_in = b_on; b_we_in = b_we; b_addr_in = b_ad; b_data_in = b_wd;

    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk_in); #1;
      for (int q = 0; q < 2; q++) begin
        if (on[q] && !we[q] && cyc == ack_cyc[q]) exp_dout[q] = rd_val[q];
      end
      exp_en   = (any && cyc == 1) || (two && cyc == 4);
      exp_busy = (any && (cyc == 1 || cyc == 2)) || (two && (cyc == 4 || cyc == 5));
      check_val("a_ack", a_ack_out, on[0] && cyc == ack_cyc[0]);
      check_val("b_ack", b_ack_out, on[1] && cyc == ack_cyc[1]);
      check_val("busy", busy_out, exp_busy);
      check_val("ram_en", ram_en_out, exp_en);
      if (exp_en) begin
        p = (cyc == 1) ? first : ~first;
        check_val("ram_we", ram_we_out, we[p]);
        check_val("ram_addr", ram_addr_out, ad[p]);
        check_val("ram_wdata", ram_wdata_out, wd[p]);
      end else begin
        check_val("ram_we_idle", ram_we_out, 1'b0);
      end
      check_val("a_data", a_data_out, exp_dout[0]);
      check_val("b_data", b_data_out, exp_dout[1]);
      // scramble the granted port's fields (and maybe drop its req) while it is in ACCESS
      if (perturb && any && cyc == 1) begin
        if (first == 1'b0) begin
          a_addr_in = 3'($urandom_range(0, 7)); a_data_in = 8'($urandom_range(0, 255));
          a_we_in = 1'($urandom_range(0, 1));   a_req_in = 1'($urandom_range(0, 1));
        end else begin
          b_addr_in = 3'($urandom_range(0, 7)); b_data_in = 8'($urandom_range(0, 255));
          b_we_in = 1'($urandom_range(0, 1));   b_req_in = 1'($urandom_range(0, 1));
        end
      end
      if (a_ack_out) a_req_in = 1'b0;
      if (b_ack_out) b_req_in = 1'b0;
    end
    a_req_in = 1'b0;
    b_req_in = 1'b0;
  endtask

  // Both ports hold read requests for 18 cycles: grants must alternate.
  task automatic run_both_hold();
    bit first, p, ea, eb;
    int k;
    first = ~last_g;
    a_req_in = 1'b1; a_we_in = 1'b0; a_addr_in = 3'd1; a_data_in = 8'h00;
    b_req_in = 1'b1; b_we_in = 1'b0; b_addr_in = 3'd2; b_data_in = 8'h00;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(posedge clk_in); #1;
      ea = 1'b0; eb = 1'b0;
      if (cyc >= 2 && (cyc - 2) % 3 == 0) begin
        k = (cyc - 2) / 3;
        p = first ^ k[0];
        if (p == 1'b0) begin ea = 1'b1; exp_dout[0] = mdl_mem[1]; end
        else           begin eb = 1'b1; exp_dout[1] = mdl_mem[2]; end
        $display("hold ack %0d: port %s", k, p ? "B" : "A");
      end
      check_val("hold_a_ack", a_ack_out, ea);
      check_val("hold_b_ack", b_ack_out, eb);
      check_val("hold_a_data", a_data_out, exp_dout[0]);
      check_val("hold_b_data", b_data_out, exp_dout[1]);
    end
    a_req_in = 1'b0;
    b_req_in = 1'b0;
    last_g = ~first;
  endtask

  // Reset asserted while an A write is in ACCESS.
  task automatic run_reset_mid();
    a_req_in = 1'b1; a_we_in = 1'b1; a_addr_in = 3'd5; a_data_in = 8'h77;
    b_req_in = 1'b0;
    @(posedge clk_in); #1;
    check_val("rst_pre_en", ram_en_out, 1'b1);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    $display("reset during ACCESS of A write r5=77");
    check_val("rst_a_ack", a_ack_out, 1'b0);
    check_val("rst_b_ack", b_ack_out, 1'b0);
    check_val("rst_a_data", a_data_out, 8'h00);
    check_val("rst_b_data", b_data_out, 8'h00);
    check_val("rst_ram_en", ram_en_out, 1'b0);
    check_val("rst_ram_we", ram_we_out, 1'b0);
    check_val("rst_ram_addr", ram_addr_out, 3'd0);
    check_val("rst_ram_wdata", ram_wdata_out, 8'h00);
    check_val("rst_busy", busy_out, 1'b0);
    rst_in = 1'b0;
    a_req_in = 1'b0;
    mdl_mem[5] = 8'h77;  // RAM itself is not reset, so the write landed
    last_g = 1'b1;
    exp_dout[0] = 8'h00;
    exp_dout[1] = 8'h00;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk_in); #1;
      check_val("post_rst_a_ack", a_ack_out, 1'b0);
      check_val("post_rst_busy", busy_out, 1'b0);
    end
  endtask

  // Fixed-priority build: A held high keeps winning; B only gets in once A drops.
  task automatic run_fixed_prio();
    bit ea, eb;
    f_a_req_in = 1'b1; f_a_we_in = 1'b0; f_a_addr_in = 3'd3; f_a_data_in = 8'h00;
    f_b_req_in = 1'b1; f_b_we_in = 1'b0; f_b_addr_in = 3'd6; f_b_data_in = 8'h00;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(posedge clk_in); #1;
      ea = (cyc <= 18) && (cyc >= 2) && ((cyc - 2) % 3 == 0);
      eb = (cyc == 20);
      check_val("fp_a_ack", f_a_ack_out, ea);
      check_val("fp_b_ack", f_b_ack_out, eb);
      if (ea) check_val("fp_a_data", f_a_data_out, 8'hA3);
      if (eb) check_val("fp_b_data", f_b_data_out, 8'hA6);
      if (ea || eb) $display("fixed-prio ack: port %s", eb ? "B" : "A");
      if (cyc == 18) f_a_req_in = 1'b0;
    end
    f_b_req_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; init_mem = 1'b1;
    a_req_in = 1'b0; a_we_in = 1'b0; a_addr_in = 3'd0; a_data_in = 8'h00;
    b_req_in = 1'b0; b_we_in = 1'b0; b_addr_in = 3'd0; b_data_in = 8'h00;
    f_a_req_in = 1'b0; f_a_we_in = 1'b0; f_a_addr_in = 3'd0; f_a_data_in = 8'h00;
    f_b_req_in = 1'b0; f_b_we_in = 1'b0; f_b_addr_in = 3'd0; f_b_data_in = 8'h00;
    for (int i = 0; i < 8; i++) mdl_mem[i] = 8'h00;
    exp_dout[0] = 8'h00;
    exp_dout[1] = 8'h00;
    last_g = 1'b1;

    repeat (3) @(posedge clk_in);
    #1;
    check_val("reset_a_ack", a_ack_out, 1'b0);
    check_val("reset_b_ack", b_ack_out, 1'b0);
    check_val("reset_a_data", a_data_out, 8'h00);
    check_val("reset_b_data", b_data_out, 8'h00);
    check_val("reset_ram_en", ram_en_out, 1'b0);
    check_val("reset_ram_we", ram_we_out, 1'b0);
    check_val("reset_ram_addr", ram_addr_out, 3'd0);
    check_val("reset_ram_wdata", ram_wdata_out, 8'h00);
    check_val("reset_busy", busy_out, 1'b0);
    rst_in = 1'b0; init_mem = 1'b0;

    // A write r3=5A then read it back
    do_round(1'b1, 1'b1, 3'd3, 8'h5A, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    do_round(1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    // simultaneous writes, then simultaneous read-back
    do_round(1'b1, 1'b1, 3'd1, 8'h11, 1'b1, 1'b1, 3'd2, 8'h22, 1'b0);
    do_round(1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    // B writes r7=C3 then B reads it with A idle
    do_round(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd7, 8'hC3, 1'b0);
    do_round(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    // request fields scrambled / req dropped during ACCESS
    do_round(1'b1, 1'b1, 3'd4, 8'h9C, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    do_round(1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

    run_both_hold();

    for (int r = 0; r < 40; r++) begin
      do_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)));
    end

    run_reset_mid();
    do_round(1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0);

    run_fixed_prio();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
